ex_alu_sequencer: RTL and testbench
===================================

EX_ALU_SEQUENCER -- requirements
Module: ex_alu_sequencer

Interface
REQ-001 Parameter MUL_CYCLES, default 4, SHALL set the multiply latency in cycles (legal range 2..16).
REQ-002 clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 id_valid  input  1  decode stage presents an ALU instruction.
REQ-005 id_ready  output  1  sequencer accepts the presented instruction this cycle.
REQ-006 aluop  input  2  class: 00 load/store add, 01 branch subtract, 10 R-type, 11 reserved.
REQ-007 funct3  input  3  instruction funct3.
REQ-008 funct7  input  1  instruction bit 30 (sub select).
REQ-009 is_mul  input  1  instruction is a multiply.
REQ-010 flush  input  1  synchronous pipeline flush.
REQ-011 ex_ready  input  1  MEM stage accepts the EX result.
REQ-012 ex_valid  output  1  EX result valid toward MEM.
REQ-013 operation  output  3  registered ALU operation code for EX.
REQ-014 illegal  output  1  registered: latched instruction has no legal encoding.
REQ-015 mul_start  output  1  one-cycle pulse launching the multiplier.
REQ-016 mul_busy  output  1  multiplier in progress.
REQ-017 stall_cnt  output  16  saturating count of stalled decode cycles.

Function
REQ-018 Decode SHALL be: aluop 00 -> 000; 01 -> 001; 10 with funct3 000 -> funct7 ? 001 : 000; 10/111 -> 010; 10/110 -> 011; 10/010 -> 101; is_mul=1 -> 100 regardless of other fields.
REQ-019 Any other non-mul combination (incl. aluop 11) SHALL give operation 111 and illegal=1; illegal=0 otherwise.
REQ-020 operation and illegal SHALL be captured only on an accept (id_valid && id_ready) and held stable until the next accept.
REQ-021 FSM states SHALL be IDLE, MUL, VALID.
REQ-022 IDLE: ex_valid=0, id_ready=1; accept of non-mul -> VALID; accept of mul -> MUL.
REQ-023 MUL: ex_valid=0, id_ready=0, mul_busy=1; down-counter loaded with MUL_CYCLES-1 on accept, decremented each cycle; at count 0 -> VALID, so ex_valid rises exactly MUL_CYCLES cycles after the accept edge.
REQ-024 VALID: ex_valid=1, id_ready=ex_ready; ex_ready with accept -> VALID (non-mul) or MUL (mul), back-to-back with no bubble; ex_ready without id_valid -> IDLE; ex_ready=0 -> stay, all outputs held.
REQ-025 mul_start SHALL be 1 in the cycle after each mul accept only; mul_busy SHALL be 1 exactly while in MUL.
REQ-026 flush=1 SHALL force id_ready=0 that cycle and return to IDLE at next edge from any state, clearing ex_valid, mul_busy and the counter; operation/illegal retain last values.
REQ-027 flush SHALL take priority over accept and ex_ready in the same cycle.
REQ-028 stall_cnt SHALL increment on each cycle with id_valid=1, id_ready=0, flush=0, and saturate at 0xFFFF.
REQ-029 Counter width SHALL be the minimum holding MUL_CYCLES-1, at least 1 bit.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, ex_valid=0, mul_start=0, mul_busy=0, counter=0, operation=000, illegal=0, stall_cnt=0, regardless of clk.
REQ-031 Reset asserted mid-multiply SHALL abort it; first accept after release SHALL behave as from IDLE.

Verification
REQ-032 aluop=10, funct3=000, funct7=1, id_valid one cycle -> next cycle ex_valid=1, operation=001, illegal=0.
REQ-033 is_mul=1 accepted, MUL_CYCLES=4, ex_ready=1 -> mul_start pulse cycle 1, mul_busy cycles 1-3, ex_valid=1 at cycle 4, operation=100, stall_cnt +3 if id_valid held.
REQ-034 VALID with ex_ready=0 for 5 cycles, id_valid=1 -> outputs held, id_ready=0, stall_cnt=5; ex_ready=1 -> new op accepted same cycle.
REQ-035 aluop=11 accepted -> operation=111, illegal=1; following aluop=00 -> 000, illegal=0.
REQ-036 flush in cycle 2 of multiply with id_valid=1 -> IDLE next edge, ex_valid=0, mul_busy=0, no accept in flush cycle.
REQ-037 rst_n low between edges during VALID -> ex_valid=0 immediately; stall_cnt forced 0xFFFF-saturation test then reset -> 0.

Source files
------------

// File: rtl/ex_alu_sequencer.sv
// EX-stage ALU sequencer: decodes the ALU operation, sequences multi-cycle
// multiplies and hands results to MEM with a valid/ready handshake.
module ex_alu_sequencer #(
  parameter int MUL_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [1:0]  aluop,
  input  logic [2:0]  funct3,
  input  logic        funct7,
  input  logic        is_mul,
  input  logic        flush,
  input  logic        ex_ready,
  output logic        ex_valid,
  output logic [2:0]  operation,
  output logic        illegal,
  output logic        mul_start,
  output logic        mul_busy,
  output logic [15:0] stall_cnt
);

  localparam int CW = (MUL_CYCLES <= 2) ? 1 : $clog2(MUL_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MUL, VALID} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          accept;
  logic [2:0]    dec_op;
  logic          dec_ill;

  // Every legal encoding maps to an op other than 111, so 111 alone marks illegal.
  always_comb begin
    dec_op = 3'b111;
    if (is_mul) dec_op = 3'b100;
    else begin
      case (aluop)
        2'b00: dec_op = 3'b000;
        2'b01: dec_op = 3'b001;
        2'b10: begin
          case (funct3)
            3'b000:  dec_op = funct7 ? 3'b001 : 3'b000;
            3'b111:  dec_op = 3'b010;
            3'b110:  dec_op = 3'b011;
            3'b010:  dec_op = 3'b101;
            default: dec_op = 3'b111;
          endcase
        end
        default: dec_op = 3'b111;
      endcase
    end
    dec_ill = (dec_op == 3'b111);
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    id_ready  = 1'b0;
    case (state)
      IDLE:    id_ready = 1'b1;
      VALID:   id_ready = ex_ready;
      default: id_ready = 1'b0;
    endcase
    if (flush) id_ready = 1'b0;
    accept = id_valid && id_ready;

    if (flush) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (accept) begin
      state_nxt = is_mul ? MUL : VALID;
      cnt_nxt   = is_mul ? CNT_LOAD : '0;
    end else begin
      case (state)
        // Loaded with MUL_CYCLES-1, so the result is valid MUL_CYCLES cycles after the accept cycle.
        MUL: begin
          cnt_nxt = cnt - CW'(1);
          if (cnt <= CW'(1)) begin
            state_nxt = VALID;
            cnt_nxt   = '0;
          end
        end
        VALID:   if (ex_ready) state_nxt = IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mul_start <= 1'b0;
      operation <= 3'b000;
      illegal   <= 1'b0;
      stall_cnt <= 16'h0000;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      mul_start <= accept && is_mul;
      if (accept) begin
        operation <= dec_op;
        illegal   <= dec_ill;
      end
      if (id_valid && !id_ready && !flush && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign ex_valid = (state == VALID);
  assign mul_busy = (state == MUL);

endmodule

// File: tb/tb_ex_alu_sequencer.sv
// Bench for ex_alu_sequencer: a result-occupancy model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_ex_alu_sequencer;
  localparam int MC = 4;

  logic clk = 1'b0, rst_n = 1'b1;
  logic id_valid = 0, funct7 = 0, is_mul = 0, flush = 0, ex_ready = 0;
  logic [1:0] aluop = 0;
  logic [2:0] funct3 = 0;
  logic id_ready, ex_valid, illegal, mul_start, mul_busy;
  logic [2:0] operation;
  logic [15:0] stall_cnt;

  ex_alu_sequencer #(.MUL_CYCLES(MC)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .aluop(aluop), .funct3(funct3), .funct7(funct7), .is_mul(is_mul),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .operation(operation), .illegal(illegal), .mul_start(mul_start),
    .mul_busy(mul_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: m_left = multiply cycles still outstanding, m_res = result held toward MEM.
  int         m_left, m_stall;
  bit         m_res, m_start, m_ill;
  logic [2:0] m_op;

  function automatic logic [2:0] dec(logic [1:0] a, logic [2:0] f3, logic f7, logic m);
    if (m) return 3'd4;
    if (a == 2'd0) return 3'd0;
    if (a == 2'd1) return 3'd1;
    if (a == 2'd2 && f3 == 3'd0) return f7 ? 3'd1 : 3'd0;
    if (a == 2'd2 && f3 == 3'd7) return 3'd2;
    if (a == 2'd2 && f3 == 3'd6) return 3'd3;
    if (a == 2'd2 && f3 == 3'd2) return 3'd5;
    return 3'd7;
  endfunction

  function automatic bit m_ready();
    return !flush && ((!m_res && m_left == 0) || (m_res && ex_ready));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_res = 0; m_start = 0; m_op = 3'd0; m_ill = 0; m_stall = 0;
    end else begin
      bit rdy, acc;
      rdy = m_ready();
      acc = id_valid && rdy;
      m_start = acc && is_mul;
      if (id_valid && !rdy && !flush && m_stall < 65535) m_stall++;
      if (flush) begin
        m_res = 0; m_left = 0;
      end else if (acc) begin
        m_op  = dec(aluop, funct3, funct7, is_mul);
        m_ill = (m_op == 3'd7);
        m_res = !is_mul;
        m_left = is_mul ? MC - 1 : 0;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_res = 1;
      end else if (m_res && ex_ready) m_res = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m.ex_valid",  32'(ex_valid),  32'(m_res));
      chk("m.id_ready",  32'(id_ready),  32'(m_ready()));
      chk("m.mul_busy",  32'(mul_busy),  32'(m_left > 0));
      chk("m.mul_start", 32'(mul_start), 32'(m_start));
      chk("m.operation", 32'(operation), 32'(m_op));
      chk("m.illegal",   32'(illegal),   32'(m_ill));
      chk("m.stall_cnt", 32'(stall_cnt), 32'(m_stall));
    end
  end

  task automatic set(logic v, logic [1:0] a, logic [2:0] f3, logic f7, logic m, logic er, logic fl);
    id_valid = v; aluop = a; funct3 = f3; funct7 = f7; is_mul = m; ex_ready = er; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  typedef struct { logic [1:0] a; logic [2:0] f3; logic f7; logic [2:0] op; logic ill; } vec_t;
  vec_t tbl[7] = '{
    '{2'd1, 3'd5, 1'b1, 3'd1, 1'b0},
    '{2'd2, 3'd0, 1'b0, 3'd0, 1'b0},
    '{2'd2, 3'd7, 1'b0, 3'd2, 1'b0},
    '{2'd2, 3'd6, 1'b0, 3'd3, 1'b0},
    '{2'd2, 3'd2, 1'b0, 3'd5, 1'b0},
    '{2'd2, 3'd1, 1'b0, 3'd7, 1'b1},
    '{2'd2, 3'd3, 1'b1, 3'd7, 1'b1}
  };

  initial begin
    #1 rst_n = 0;
    #1;
    chk("rst.ex_valid",  32'(ex_valid), 0);
    chk("rst.mul_busy",  32'(mul_busy), 0);
    chk("rst.mul_start", 32'(mul_start), 0);
    chk("rst.operation", 32'(operation), 0);
    chk("rst.illegal",   32'(illegal), 0);
    chk("rst.stall_cnt", 32'(stall_cnt), 0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1;

    // Single-cycle R-type subtract.
    set(1, 2'd2, 3'd0, 1, 0, 0, 0); tick();
    chk("sub.ex_valid", 32'(ex_valid), 1);
    chk("sub.op", 32'(operation), 1);
    chk("sub.ill", 32'(illegal), 0);

    // Reserved class then a legal one, back-to-back.
    set(1, 2'd3, 3'd0, 0, 0, 1, 0); tick();
    chk("rsv.op", 32'(operation), 7);
    chk("rsv.ill", 32'(illegal), 1);
    set(1, 2'd0, 3'd0, 0, 0, 1, 0); tick();
    chk("ls.op", 32'(operation), 0);
    chk("ls.ill", 32'(illegal), 0);
    chk("ls.ex_valid", 32'(ex_valid), 1);

    foreach (tbl[i]) begin
      set(1, tbl[i].a, tbl[i].f3, tbl[i].f7, 0, 1, 0); tick();
      chk($sformatf("dec%0d.op", i), 32'(operation), 32'(tbl[i].op));
      chk($sformatf("dec%0d.ill", i), 32'(illegal), 32'(tbl[i].ill));
    end
    set(0, 2'd0, 3'd0, 0, 0, 1, 0); tick();
    chk("drain.ex_valid", 32'(ex_valid), 0);

    // Multiply with id_valid held: 3 stalled cycles, then next op accepted.
    set(1, 2'd0, 3'd0, 0, 1, 1, 0); tick();
    chk("mul.start", 32'(mul_start), 1);
    chk("mul.busy1", 32'(mul_busy), 1);
    set(1, 2'd0, 3'd0, 0, 0, 1, 0); tick();
    chk("mul.start2", 32'(mul_start), 0);
    chk("mul.busy2", 32'(mul_busy), 1);
    tick();
    chk("mul.busy3", 32'(mul_busy), 1);
    chk("mul.ev3", 32'(ex_valid), 0);
    tick();
    chk("mul.ev4", 32'(ex_valid), 1);
    chk("mul.busy4", 32'(mul_busy), 0);
    chk("mul.op", 32'(operation), 4);
    chk("mul.stall", 32'(stall_cnt), 3);
    tick();
    chk("mul.next_op", 32'(operation), 0);
    chk("mul.next_stall", 32'(stall_cnt), 3);

    // MEM back-pressure for 5 cycles.
    set(1, 2'd2, 3'd7, 0, 0, 0, 0);
    repeat (5) tick();
    chk("bp.stall", 32'(stall_cnt), 8);
    chk("bp.op_held", 32'(operation), 0);
    chk("bp.id_ready", 32'(id_ready), 0);
    ex_ready = 1; #1;
    chk("bp.ready_same_cycle", 32'(id_ready), 1);
    tick();
    chk("bp.new_op", 32'(operation), 2);
    chk("bp.stall_after", 32'(stall_cnt), 8);

    // Flush in cycle 2 of a multiply.
    set(0, 2'd0, 3'd0, 0, 0, 1, 0); tick();
    set(1, 2'd0, 3'd0, 0, 1, 1, 0); tick();
    set(1, 2'd0, 3'd0, 0, 0, 1, 0); tick();
    set(1, 2'd0, 3'd0, 0, 0, 1, 1); #1;
    chk("fl.id_ready", 32'(id_ready), 0);
    tick();
    chk("fl.ex_valid", 32'(ex_valid), 0);
    chk("fl.busy", 32'(mul_busy), 0);
    chk("fl.op_kept", 32'(operation), 4);
    chk("fl.stall", 32'(stall_cnt), 9);
    set(1, 2'd1, 3'd0, 0, 0, 1, 0); tick();
    chk("fl.after_op", 32'(operation), 1);
    chk("fl.after_ev", 32'(ex_valid), 1);

    // Reset in the middle of a multiply.
    set(1, 2'd0, 3'd0, 0, 1, 1, 0); tick();
    set(0, 2'd0, 3'd0, 0, 0, 1, 0); tick();
    #2 rst_n = 0; #1;
    chk("rm.busy", 32'(mul_busy), 0);
    chk("rm.op", 32'(operation), 0);
    chk("rm.stall", 32'(stall_cnt), 0);
    @(posedge clk); #1 rst_n = 1;
    set(1, 2'd1, 3'd0, 0, 0, 1, 0); tick();
    chk("rm.first_ev", 32'(ex_valid), 1);
    chk("rm.first_op", 32'(operation), 1);
    chk("rm.first_busy", 32'(mul_busy), 0);

    // Stall counter saturation, then asynchronous reset between edges.
    set(1, 2'd2, 3'd2, 0, 0, 0, 0);
    repeat (65540) tick();
    chk("sat.stall", 32'(stall_cnt), 32'hFFFF);
    chk("sat.ev", 32'(ex_valid), 1);
    #2 rst_n = 0; #1;
    chk("ar.ex_valid", 32'(ex_valid), 0);
    chk("ar.stall", 32'(stall_cnt), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
